pipe_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates the write-enable, flush, hold and PC-select controls that stall, bubble, redirect and freeze the pipeline.
- Covers load-use hazards, taken branches, jumps/eret, undefined-instruction and bus-error exceptions, external interrupts, and data-memory wait states with timeout.
- Sits beside the ID-stage decoder; its outputs drive the stage registers and the PC mux.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 31 +++
 rtl/pipe_hazard_ctrl_if.sv | 44 ++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 15 +
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard sequencer: FSM states, PC mux
// selects and exception cause codes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MWAIT,
        ST_BUSERR
    } state_t;

    typedef enum logic [2:0] {
        PC_SEL_PC4    = 3'd0,
        PC_SEL_BRANCH = 3'd1,
        PC_SEL_JUMP   = 3'd2,
        PC_SEL_ISR    = 3'd3,
        PC_SEL_EXC    = 3'd4,
        PC_SEL_EPC    = 3'd5
    } pc_sel_t;

    // Vector addresses selected by PC_SEL_ISR / PC_SEL_EXC at the PC mux
    localparam logic [31:0] ISR_VECTOR = 32'h8000_0004;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_UNDEF  = 2'd1,
        CAUSE_BUSERR = 2'd2,
        CAUSE_IRQ    = 2'd3
    } exc_cause_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decoder/pipeline-side signal bundle of the hazard sequencer; master is the
// pipeline (drives decode/status), slave is the sequencer (drives controls).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_valid;
    logic             id_jump;
    logic             id_eret;
    logic             id_undef;
    logic             ex_memrd;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             irq;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             pipe_hold;
    logic [2:0]       pc_sel;
    logic             epc_write;
    logic [1:0]       exc_cause;
    logic             k_mode;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_valid, id_jump, id_eret, id_undef,
               ex_memrd, ex_rt, ex_branch_taken, mem_req, mem_ready, irq,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
               pipe_hold, pc_sel, epc_write, exc_cause, k_mode, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_valid, id_jump, id_eret, id_undef,
               ex_memrd, ex_rt, ex_branch_taken, mem_req, mem_ready, irq,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
               pipe_hold, pc_sel, epc_write, exc_cause, k_mode, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination is read by the ID
// instruction. Register 0 never hazards.
module hazard_detect (
    input  logic       ex_memrd,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);
    always_comb begin
        load_use = ex_memrd && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: stall, bubble, redirect and freeze controls for
// the stage registers and PC mux, plus exception/kernel-mode bookkeeping.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(MEM_TIMEOUT);

    state_t           state, state_nxt;
    logic [TO_W-1:0]  wcnt, wcnt_nxt;
    logic             k_mode, k_nxt;
    exc_cause_t       cause, cause_nxt;
    logic [CNT_W-1:0] stall_cnt;

    logic             load_use;
    logic             run_eval;
    logic             pc_write_c, if_id_write_c, if_id_flush_c, id_ex_flush_c;
    logic             ex_mem_flush_c, pipe_hold_c, epc_write_c;
    pc_sel_t          pc_sel_c;

    hazard_detect u_hazard_detect (
        .ex_memrd   (bus.ex_memrd),
        .ex_rt      (bus.ex_rt),
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .id_uses_rt (bus.id_uses_rt),
        .load_use   (load_use)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            wcnt      <= '0;
            k_mode    <= 1'b1;
            cause     <= CAUSE_NONE;
            stall_cnt <= '0;
        end else begin
            state  <= state_nxt;
            wcnt   <= wcnt_nxt;
            k_mode <= k_nxt;
            cause  <= cause_nxt;
            if (!pc_write_c && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        pc_write_c     = 1'b1;
        if_id_write_c  = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        pipe_hold_c    = 1'b0;
        epc_write_c    = 1'b0;
        pc_sel_c       = PC_SEL_PC4;
        state_nxt      = state;
        wcnt_nxt       = wcnt;
        k_nxt          = k_mode;
        cause_nxt      = cause;
        run_eval       = 1'b0;

        case (state)
            ST_RUN: run_eval = 1'b1;
            ST_MWAIT: begin
                // The ready cycle is an ordinary RUN cycle, so its own events apply
                if (bus.mem_ready) begin
                    run_eval  = 1'b1;
                    state_nxt = ST_RUN;
                    wcnt_nxt  = '0;
                end else begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    pipe_hold_c   = 1'b1;
                    wcnt_nxt      = wcnt + 1'b1;
                    if (wcnt_nxt >= TIMEOUT_CNT) begin
                        state_nxt = ST_BUSERR;
                        wcnt_nxt  = '0;
                    end
                end
            end
            ST_BUSERR: begin
                pc_sel_c       = PC_SEL_EXC;
                if_id_flush_c  = 1'b1;
                id_ex_flush_c  = 1'b1;
                ex_mem_flush_c = 1'b1;
                epc_write_c    = 1'b1;
                cause_nxt      = CAUSE_BUSERR;
                k_nxt          = 1'b1;
                state_nxt      = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase

        if (run_eval) begin
            if (bus.mem_req && !bus.mem_ready) begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                pipe_hold_c   = 1'b1;
                state_nxt     = ST_MWAIT;
                wcnt_nxt      = TO_W'(1);
            end else if (bus.ex_branch_taken) begin
                pc_sel_c      = PC_SEL_BRANCH;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
            end else if (bus.id_valid && (bus.id_undef || (bus.id_eret && !k_mode))) begin
                // eret outside kernel mode is privileged, so it traps as undefined
                pc_sel_c      = PC_SEL_EXC;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                epc_write_c   = 1'b1;
                cause_nxt     = CAUSE_UNDEF;
                k_nxt         = 1'b1;
            end else if (bus.irq && !k_mode && bus.id_valid) begin
                pc_sel_c      = PC_SEL_ISR;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                epc_write_c   = 1'b1;
                cause_nxt     = CAUSE_IRQ;
                k_nxt         = 1'b1;
            end else if (load_use) begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                id_ex_flush_c = 1'b1;
            end else if (bus.id_eret && k_mode) begin
                pc_sel_c      = PC_SEL_EPC;
                if_id_flush_c = 1'b1;
                k_nxt         = 1'b0;
            end else if (bus.id_jump) begin
                pc_sel_c      = PC_SEL_JUMP;
                if_id_flush_c = 1'b1;
            end
        end
    end

    always_comb begin
        if (!reset) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.if_id_flush  = 1'b1;
            bus.id_ex_flush  = 1'b1;
            bus.ex_mem_flush = 1'b0;
            bus.pipe_hold    = 1'b0;
            bus.pc_sel       = PC_SEL_PC4;
            bus.epc_write    = 1'b0;
        end else begin
            bus.pc_write     = pc_write_c;
            bus.if_id_write  = if_id_write_c;
            bus.if_id_flush  = if_id_flush_c;
            bus.id_ex_flush  = id_ex_flush_c;
            bus.ex_mem_flush = ex_mem_flush_c;
            bus.pipe_hold    = pipe_hold_c;
            bus.pc_sel       = pc_sel_c;
            bus.epc_write    = epc_write_c;
        end
    end

    assign bus.exc_cause = cause;
    assign bus.k_mode    = k_mode;
    assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic, every cycle compared against a rule-level behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 16;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model: consecutive freeze cycles so far, pending bus-error cycle, registers
    int   m_wait   = 0;
    bit   m_buserr = 1'b0;
    bit   m_k      = 1'b1;
    int   m_cause  = 0;
    int   m_stall  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (5),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b0; bus.id_valid = 1'b1;
        bus.id_jump = 1'b0; bus.id_eret = 1'b0; bus.id_undef = 1'b0;
        bus.ex_memrd = 1'b0; bus.ex_rt = 5'd0; bus.ex_branch_taken = 1'b0;
        bus.mem_req = 1'b0; bus.mem_ready = 1'b1; bus.irq = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied; returns at the next one
    task automatic step();
        bit e_pcw, e_ifw, e_iff, e_idf, e_exf, e_hold, e_epc, lu, n_buserr, n_k;
        int e_sel, n_wait, n_cause;
        #1;
        if (!reset) begin
            m_wait = 0; m_buserr = 1'b0; m_k = 1'b1; m_cause = 0; m_stall = 0;
        end
        e_pcw = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_exf = 0; e_hold = 0; e_epc = 0; e_sel = 0;
        n_wait = m_wait; n_buserr = m_buserr; n_k = m_k; n_cause = m_cause;
        lu = bus.ex_memrd && bus.ex_rt != 0 &&
             (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
        if (!reset) begin
            e_pcw = 0; e_ifw = 0; e_iff = 1; e_idf = 1;
        end else if (m_buserr) begin
            e_sel = 4; e_iff = 1; e_idf = 1; e_exf = 1; e_epc = 1;
            n_buserr = 0; n_cause = 2; n_k = 1;
        end else if (m_wait > 0 && !bus.mem_ready) begin
            e_pcw = 0; e_ifw = 0; e_hold = 1;
            n_wait = m_wait + 1;
            if (n_wait >= MEM_TIMEOUT) begin n_wait = 0; n_buserr = 1; end
        end else begin
            n_wait = 0;
            if (bus.mem_req && !bus.mem_ready) begin
                e_pcw = 0; e_ifw = 0; e_hold = 1; n_wait = 1;
            end else if (bus.ex_branch_taken) begin
                e_sel = 1; e_iff = 1; e_idf = 1;
            end else if (bus.id_valid && (bus.id_undef || (bus.id_eret && !m_k))) begin
                e_sel = 4; e_iff = 1; e_idf = 1; e_epc = 1; n_cause = 1; n_k = 1;
            end else if (bus.irq && !m_k && bus.id_valid) begin
                e_sel = 3; e_iff = 1; e_idf = 1; e_epc = 1; n_cause = 3; n_k = 1;
            end else if (lu) begin
                e_pcw = 0; e_ifw = 0; e_idf = 1;
            end else if (bus.id_eret && m_k) begin
                e_sel = 5; e_iff = 1; n_k = 0;
            end else if (bus.id_jump) begin
                e_sel = 2; e_iff = 1;
            end
        end
        check_eq("pc_write",     32'(bus.pc_write),     32'(e_pcw));
        check_eq("if_id_write",  32'(bus.if_id_write),  32'(e_ifw));
        check_eq("if_id_flush",  32'(bus.if_id_flush),  32'(e_iff));
        check_eq("id_ex_flush",  32'(bus.id_ex_flush),  32'(e_idf));
        check_eq("ex_mem_flush", 32'(bus.ex_mem_flush), 32'(e_exf));
        check_eq("pipe_hold",    32'(bus.pipe_hold),    32'(e_hold));
        check_eq("pc_sel",       32'(bus.pc_sel),       32'(e_sel));
        check_eq("epc_write",    32'(bus.epc_write),    32'(e_epc));
        check_eq("exc_cause",    32'(bus.exc_cause),    32'(m_cause));
        check_eq("k_mode",       32'(bus.k_mode),       32'(m_k));
        check_eq("stall_cnt",    32'(bus.stall_cnt),    32'(m_stall));
        @(posedge clk);
        if (reset) begin
            m_wait = n_wait; m_buserr = n_buserr; m_k = n_k; m_cause = n_cause;
            if (!e_pcw && m_stall < CNT_MAX) m_stall++;
        end
        @(negedge clk);
    endtask

    int burst;

    initial begin
        idle_inputs();
        @(negedge clk);
        step();
        step();
        reset = 1'b1;
        step();

        // Load-use on rs, then the same with ex_rt=0
        bus.ex_memrd = 1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5; step();
        bus.ex_memrd = 0; step();
        bus.ex_memrd = 1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0; step();
        idle_inputs(); step();

        // Leave kernel mode, then a branch must beat irq and undef
        bus.id_eret = 1; step();
        idle_inputs();
        bus.ex_branch_taken = 1; bus.irq = 1; bus.id_undef = 1; step();
        idle_inputs(); step();

        // Interrupt, irq held (masked), eret back to user mode
        bus.irq = 1; step(); step(); step();
        bus.irq = 0; bus.id_eret = 1; step();
        idle_inputs(); step();

        // Three-cycle memory wait released by ready
        bus.mem_req = 1; bus.mem_ready = 0;
        repeat (3) step();
        bus.mem_ready = 1; step();
        idle_inputs(); step();

        // Timeout into bus error
        bus.mem_req = 1; bus.mem_ready = 0;
        repeat (MEM_TIMEOUT + 2) step();
        idle_inputs(); step();

        // Reset mid-wait
        bus.mem_req = 1; bus.mem_ready = 0;
        repeat (7) step();
        reset = 1'b0; step();
        reset = 1'b1; idle_inputs(); step(); step();

        // Random traffic
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            bus.id_rs           = 5'($urandom_range(0, 3));
            bus.id_rt           = 5'($urandom_range(0, 3));
            bus.ex_rt           = 5'($urandom_range(0, 3));
            bus.id_uses_rt      = 1'($urandom_range(0, 1));
            bus.id_valid        = ($urandom_range(0, 7) != 0);
            bus.id_jump         = ($urandom_range(0, 7) == 0);
            bus.id_eret         = ($urandom_range(0, 7) == 0);
            bus.id_undef        = ($urandom_range(0, 15) == 0);
            bus.ex_memrd        = ($urandom_range(0, 2) == 0);
            bus.ex_branch_taken = ($urandom_range(0, 7) == 0);
            bus.irq             = ($urandom_range(0, 3) == 0);
            if (burst == 0 && $urandom_range(0, 39) == 0)
                burst = $urandom_range(5, 20);
            if (burst > 0) begin
                bus.mem_req = 1; bus.mem_ready = 0; burst--;
            end else begin
                bus.mem_req   = ($urandom_range(0, 2) == 0);
                bus.mem_ready = ($urandom_range(0, 3) != 0);
            end
            reset = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
